// File: rtl/bcd_disp_pkg.sv
// Shared types and helpers for the BCD counter/display block: state encoding,
// digit width and the active-low 7-segment decoder.
package bcd_disp_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_UP   = 3'b001,
        ST_DOWN = 3'b010,
        ST_EDIT = 3'b100
    } state_e;

    // Active-low segments, bit 0 = a .. bit 6 = g; non-BCD input blanks the digit.
    function automatic logic [6:0] seg_decode(input logic [BCD_W-1:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/bcd_counter_disp_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
// The debounced level flips only after DB_CYCLES consecutive differing samples.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk_100M,
    input  logic clr,
    input  logic btn,
    output logic pulse
);

    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          pulse_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk_100M) begin
        if (clr) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            pulse_q <= level_d & ~level_q;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/bcd_counter_disp.sv
// N-digit BCD up/down counter with button FSM, per-digit edit and multiplexed 7-seg scan.
// Define CNT_SAT_EN to saturate at all-9s / all-0s instead of wrapping (wrap then stays 0).
module bcd_counter_disp
    import bcd_disp_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter int TICK_DIV  = 100_000_000,
    parameter int SCAN_DIV  = 100_000,
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic                    clk_100M,
    input  logic                    clr,
    input  logic                    inc,
    input  logic                    set,
    output logic [6:0]              seg,
    output logic [DIGITS-1:0]       scan,
    output logic [2:0]              state,
    output logic [BCD_W*DIGITS-1:0] count_bcd,
    output logic                    wrap
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1)   ? $clog2(DIGITS)   : 1;

    typedef logic [DIGITS-1:0][BCD_W-1:0] digits_t;

    logic              inc_p, set_p;
    logic              tick, scan_en;
    logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
    logic [SW-1:0]     scan_cnt_q, scan_cnt_d;
    state_e            state_q, state_d;
    digits_t           digits_q, digits_d;
    logic [IW-1:0]     edit_idx_q, edit_idx_d;
    logic [IW-1:0]     scan_idx_q, scan_idx_d;
    logic              wrap_q, wrap_d;
    logic              all9, all0;
    logic [DIGITS-1:0] scan_q, scan_d;
    logic [6:0]        seg_q, seg_d;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_inc_db (
        .clk_100M (clk_100M),
        .clr      (clr),
        .btn      (inc),
        .pulse    (inc_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_set_db (
        .clk_100M (clk_100M),
        .clr      (clr),
        .btn      (set),
        .pulse    (set_p)
    );

    function automatic digits_t bcd_incr(input digits_t v);
        digits_t r;
        logic    c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (c) begin
                if (v[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i] = v[i] + 4'd1;
                    c    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic digits_t bcd_decr(input digits_t v);
        digits_t r;
        logic    b;
        r = v;
        b = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (b) begin
                if (v[i] == 4'd0) begin
                    r[i] = 4'd9;
                end else begin
                    r[i] = v[i] - 4'd1;
                    b    = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign scan_en    = (scan_cnt_q == SW'(SCAN_DIV - 1));
    assign tick_cnt_d = tick    ? '0 : tick_cnt_q + TW'(1);
    assign scan_cnt_d = scan_en ? '0 : scan_cnt_q + SW'(1);

    always_comb begin
        all9 = 1'b1;
        all0 = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits_q[i] != 4'd9) all9 = 1'b0;
            if (digits_q[i] != 4'd0) all0 = 1'b0;
        end
    end

    // Button transitions and tick counting; ticks act on the pre-transition state.
    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        edit_idx_d = edit_idx_q;
        wrap_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (set_p) begin
                    state_d    = ST_EDIT;
                    edit_idx_d = '0;
                end else if (inc_p) begin
                    state_d = ST_UP;
                end
            end
            ST_UP: begin
                if (set_p)      state_d = ST_IDLE;
                else if (inc_p) state_d = ST_DOWN;
            end
            ST_DOWN: begin
                if (set_p)      state_d = ST_IDLE;
                else if (inc_p) state_d = ST_UP;
            end
            ST_EDIT: begin
                if (set_p) begin
                    if (edit_idx_q == IW'(DIGITS - 1)) state_d = ST_IDLE;
                    else                               edit_idx_d = edit_idx_q + IW'(1);
                end else if (inc_p) begin
                    digits_d[edit_idx_q] = (digits_q[edit_idx_q] == 4'd9) ? 4'd0
                                                                          : digits_q[edit_idx_q] + 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (tick && state_q == ST_UP) begin
`ifdef CNT_SAT_EN
            if (!all9) digits_d = bcd_incr(digits_q);
`else
            digits_d = bcd_incr(digits_q);
            wrap_d   = all9;
`endif
        end else if (tick && state_q == ST_DOWN) begin
`ifdef CNT_SAT_EN
            if (!all0) digits_d = bcd_decr(digits_q);
`else
            digits_d = bcd_decr(digits_q);
            wrap_d   = all0;
`endif
        end
    end

    // Display registers are fed from next-state values so scan and seg always match the stored count.
    always_comb begin
        scan_idx_d = scan_idx_q;
        if (scan_en) begin
            scan_idx_d = (scan_idx_q == IW'(DIGITS - 1)) ? '0 : scan_idx_q + IW'(1);
        end
        scan_d = ~(DIGITS'(1) << scan_idx_d);
        seg_d  = seg_decode(digits_d[scan_idx_d]);
    end

    always_ff @(posedge clk_100M) begin
        if (clr) begin
            tick_cnt_q <= '0;
            scan_cnt_q <= '0;
            state_q    <= ST_IDLE;
            digits_q   <= '0;
            edit_idx_q <= '0;
            scan_idx_q <= '0;
            wrap_q     <= 1'b0;
            scan_q     <= ~(DIGITS'(1));
            seg_q      <= 7'b1000000;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            scan_cnt_q <= scan_cnt_d;
            state_q    <= state_d;
            digits_q   <= digits_d;
            edit_idx_q <= edit_idx_d;
            scan_idx_q <= scan_idx_d;
            wrap_q     <= wrap_d;
            scan_q     <= scan_d;
            seg_q      <= seg_d;
        end
    end

    assign seg       = seg_q;
    assign scan      = scan_q;
    assign state     = state_q;
    assign count_bcd = digits_q;
    assign wrap      = wrap_q;

endmodule
